// File: rtl/cpu_ctrl_if.sv
// Memory handshake bundle between the CPU controller and its instruction/data memories.
interface cpu_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    // Controller side: issues requests, receives acks and fetched words.
    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    // Memory side: answers requests.
    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for a 16-bit load/store CPU: sequences fetch, decode,
// execute, memory and write-back, drives the datapath strobes and owns pc/ir.
module cpu_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    cpu_ctrl_if.master        mem,
    input  logic              alu_zero,
    output logic              mdr_load,
    output logic [15:0]       pc,
    output logic [3:0]        rf_rs_addr,
    output logic [3:0]        rf_rt_addr,
    output logic [3:0]        rf_rd_addr,
    output logic              rf_write_en,
    output logic              rf_wdata_sel,
    output logic [2:0]        alu_op,
    output logic              alu_src_imm,
    output logic [15:0]       imm,
    output logic              halted,
    output logic              fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Timeout fires when the counter already holds LIMIT-1 unacked cycles and the
    // current cycle is unacked too, so an ack on the limit cycle still wins.
    localparam bit          TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [15:0] WAIT_LAST  = TIMEOUT_EN ? 16'(WAIT_LIMIT - 1) : 16'd0;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] wait_q, wait_d;

    logic [3:0]  opcode;
    logic [15:0] br_off;
    logic [15:0] wait_inc;
    logic        wait_expired;

    assign opcode       = ir_q[15:12];
    assign br_off       = {{12{ir_q[11]}}, ir_q[11:8]};
    assign wait_inc     = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
    assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);

    // Next-state, pc, ir and wait-counter logic; counter resets whenever a state is left or entered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = 16'd0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_JMP: begin
                        pc_d    = {4'h0, ir_q[11:0]};
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        if (alu_zero) pc_d = pc_q + br_off;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset that also aborts any open handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    // Handshake strobes and status flags decoded from the current state (mdr_load also needs the ack).
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        mdr_load     = 1'b0;
        rf_write_en  = 1'b0;
        rf_wdata_sel = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_FETCH: mem.imem_req = 1'b1;
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (opcode == OP_SW);
                mdr_load     = (opcode == OP_LW) && mem.dmem_ack;
            end
            S_WB: begin
                rf_write_en  = 1'b1;
                rf_wdata_sel = (opcode == OP_LW);
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    // ALU control follows ir so the operand/address path stays stable through MEM and WB.
    always_comb begin
        alu_op      = 3'b000;
        alu_src_imm = 1'b0;
        case (opcode)
            OP_ADD:       alu_op = 3'b000;
            OP_ADDI: begin
                alu_op      = 3'b000;
                alu_src_imm = 1'b1;
            end
            OP_SUB, OP_BEQ: alu_op = 3'b001;
            OP_AND:       alu_op = 3'b010;
            OP_OR:        alu_op = 3'b011;
            OP_XOR:       alu_op = 3'b100;
            OP_LW, OP_SW: alu_op = 3'b101;
            default:      alu_op = 3'b000;
        endcase
    end

    assign pc         = pc_q;
    assign rf_rs_addr = ir_q[7:4];
    assign rf_rt_addr = ir_q[3:0];
    assign rf_rd_addr = ir_q[11:8];
    assign imm        = {{12{ir_q[3]}}, ir_q[3:0]};

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed vector table, hand sequences for
// timeout/reset/halt/wrap corners, and randomized instructions against a model.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        alu_zero;
    logic        mdr_load;
    logic [15:0] pc;
    logic [3:0]  rf_rs_addr, rf_rt_addr, rf_rd_addr;
    logic        rf_write_en, rf_wdata_sel;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic        halted, fault;

    cpu_ctrl_if bus ();

    cpu_ctrl #(.RESET_PC(16'h0000), .WAIT_LIMIT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem         (bus),
        .alu_zero    (alu_zero),
        .mdr_load    (mdr_load),
        .pc          (pc),
        .rf_rs_addr  (rf_rs_addr),
        .rf_rt_addr  (rf_rt_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_write_en (rf_write_en),
        .rf_wdata_sel(rf_wdata_sel),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int          cycles;
        int          wr;
        logic        sel;
        logic [3:0]  rd, rs, rt;
        int          dreq;
        logic        we;
        int          mdr;
        logic [2:0]  op;
        logic        imm_sel;
        logic [15:0] pc;
        logic        halted;
    } res_t;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        int          dw;
        int          cyc;
        logic [2:0]  op;
        logic        imm_sel;
        int          wr;
        logic        sel;
        int          dreq;
        logic        we;
        int          mdr;
        logic [15:0] pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Reference: what one instruction must do, derived from the ISA rules.
    function automatic res_t model(input logic [15:0] ins, input int dw, input logic z, input logic [15:0] pc0);
        res_t e;
        int   off;
        e = '{default: 0};
        e.cycles = 3;
        e.pc = 16'(int'(pc0) + 1);
        case (ins[15:12])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7: begin
                e.cycles = 4;
                e.wr = 1;
                case (ins[15:12])
                    4'h2: e.op = 3'd1;
                    4'h3: e.op = 3'd2;
                    4'h4: e.op = 3'd3;
                    4'h5: e.op = 3'd4;
                    default: e.op = 3'd0;
                endcase
                e.imm_sel = (ins[15:12] == 4'h7);
            end
            4'h8: begin
                e.cycles = 5 + dw;
                e.wr = 1;
                e.sel = 1'b1;
                e.dreq = dw + 1;
                e.mdr = 1;
                e.op = 3'd5;
            end
            4'h9: begin
                e.cycles = 4 + dw;
                e.dreq = dw + 1;
                e.we = 1'b1;
                e.op = 3'd5;
            end
            4'hA: begin
                e.op = 3'd1;
                off = ins[11] ? int'(ins[11:8]) - 16 : int'(ins[11:8]);
                if (z) e.pc = 16'(int'(pc0) + 1 + off);
            end
            4'hB: begin
                e.cycles = 2;
                e.pc = 16'(int'(ins) % 4096);
            end
            4'hF: begin
                e.cycles = 2;
                e.halted = 1'b1;
            end
            default: ;
        endcase
        if (e.wr != 0) begin
            e.rd = ins[11:8];
            e.rs = ins[7:4];
            e.rt = ins[3:0];
        end
        return e;
    endfunction

    // Serve one instruction from FETCH back to the next FETCH (or HALT/FAULT).
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input logic z,
                             input bit noise, output res_t r);
        int c;
        int dr;
        r = '{default: 0};
        alu_zero = z;
        for (int k = 0; k < iw; k++) begin
            bus.imem_ack = 1'b0;
            chk("imem_req_held", {31'd0, bus.imem_req}, 32'd1);
            step();
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = ins;
        #1;
        chk("imem_req_ack", {31'd0, bus.imem_req}, 32'd1);
        step();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'($urandom);
        c = 1;
        dr = 0;
        while (!bus.imem_req && !halted && !fault && c < 64) begin
            if (bus.dmem_req) begin
                dr++;
                r.we = r.we | bus.dmem_we;
                bus.dmem_ack = (dr > dw);
            end else begin
                bus.dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (mdr_load) r.mdr++;
            if (rf_write_en) begin
                r.wr++;
                r.sel = rf_wdata_sel;
                r.rd = rf_rd_addr;
                r.rs = rf_rs_addr;
                r.rt = rf_rt_addr;
            end
            if (c == 2) begin
                r.op = alu_op;
                r.imm_sel = alu_src_imm;
            end
            step();
            bus.dmem_ack = 1'b0;
            bus.imem_ack = 1'b0;
            c++;
        end
        r.cycles = c;
        r.dreq = dr;
        r.pc = pc;
        r.halted = halted;
    endtask

    task automatic cmp(input string tag, input res_t r, input res_t e);
        chk({tag, ".cycles"}, r.cycles, e.cycles);
        chk({tag, ".wr"}, r.wr, e.wr);
        chk({tag, ".sel"}, {31'd0, r.sel}, {31'd0, e.sel});
        chk({tag, ".rd"}, {28'd0, r.rd}, {28'd0, e.rd});
        chk({tag, ".rs"}, {28'd0, r.rs}, {28'd0, e.rs});
        chk({tag, ".rt"}, {28'd0, r.rt}, {28'd0, e.rt});
        chk({tag, ".dreq"}, r.dreq, e.dreq);
        chk({tag, ".we"}, {31'd0, r.we}, {31'd0, e.we});
        chk({tag, ".mdr"}, r.mdr, e.mdr);
        chk({tag, ".alu_op"}, {29'd0, r.op}, {29'd0, e.op});
        chk({tag, ".imm_sel"}, {31'd0, r.imm_sel}, {31'd0, e.imm_sel});
        chk({tag, ".pc"}, {16'd0, r.pc}, {16'd0, e.pc});
        chk({tag, ".halted"}, {31'd0, r.halted}, {31'd0, e.halted});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t        vt[14];
        res_t        r, e;
        logic [15:0] mpc;
        logic [3:0]  rop;
        logic [15:0] rins;
        int          iw, dw;
        logic        z;

        vt[0]  = '{16'h1321, 1'b0, 0, 4, 3'd0, 1'b0, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[1]  = '{16'h2321, 1'b0, 0, 4, 3'd1, 1'b0, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[2]  = '{16'h3456, 1'b0, 0, 4, 3'd2, 1'b0, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[3]  = '{16'h4456, 1'b0, 0, 4, 3'd3, 1'b0, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[4]  = '{16'h5456, 1'b0, 0, 4, 3'd4, 1'b0, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[5]  = '{16'h7ABF, 1'b0, 0, 4, 3'd0, 1'b1, 1, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[6]  = '{16'h8450, 1'b0, 3, 8, 3'd5, 1'b0, 1, 1'b1, 4, 1'b0, 1, 16'h0011};
        vt[7]  = '{16'h9450, 1'b0, 0, 4, 3'd5, 1'b0, 0, 1'b0, 1, 1'b1, 0, 16'h0011};
        vt[8]  = '{16'hA312, 1'b1, 0, 3, 3'd1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h0014};
        vt[9]  = '{16'hAE12, 1'b1, 0, 3, 3'd1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h000F};
        vt[10] = '{16'hA312, 1'b0, 0, 3, 3'd1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[11] = '{16'hB123, 1'b0, 0, 2, 3'd0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h0123};
        vt[12] = '{16'h0000, 1'b0, 0, 3, 3'd0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h0011};
        vt[13] = '{16'h6FFF, 1'b0, 0, 3, 3'd0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 16'h0011};

        rst = 1'b0;
        start = 1'b0;
        alu_zero = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.dmem_ack = 1'b0;

        // Reset state and start gating.
        do_reset();
        chk("rst.pc", {16'd0, pc}, 32'h0);
        chk("rst.imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst.dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.fault", {31'd0, fault}, 32'd0);
        chk("rst.rf_write_en", {31'd0, rf_write_en}, 32'd0);
        chk("rst.rd_addr", {28'd0, rf_rd_addr}, 32'd0);
        step();
        step();
        chk("idle.no_start", {31'd0, bus.imem_req}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start.fetch", {31'd0, bus.imem_req}, 32'd1);
        $display("reset/start sequence done");

        // First ADD after reset, then branch back across zero to exercise pc wrap.
        mpc = 16'h0000;
        run_instr(16'h1321, 0, 0, 1'b0, 1'b0, r);
        e = model(16'h1321, 0, 1'b0, mpc);
        cmp("add_first", r, e);
        chk("add_first.pc1", {16'd0, r.pc}, 32'h1);
        mpc = e.pc;
        $display("ADD 1321: cycles=%0d pc=%h", r.cycles, r.pc);
        run_instr(16'hAD00, 0, 0, 1'b1, 1'b0, r);
        chk("wrap.pc_ffff", {16'd0, r.pc}, 32'hFFFF);
        run_instr(16'h0000, 0, 0, 1'b0, 1'b0, r);
        chk("wrap.pc_0000", {16'd0, r.pc}, 32'h0000);
        mpc = 16'h0000;
        $display("pc wrap: FFFF fetch -> pc=%h", r.pc);

        // Directed vector table, each run from pc 0x0010 reached by a jump.
        for (int i = 0; i < 14; i++) begin
            run_instr(16'hB010, 0, 0, 1'b0, 1'b0, r);
            chk("vec.jmp_pc", {16'd0, r.pc}, 32'h0010);
            run_instr(vt[i].ins, 0, vt[i].dw, vt[i].z, 1'b0, r);
            e = '{default: 0};
            e.cycles = vt[i].cyc;
            e.op = vt[i].op;
            e.imm_sel = vt[i].imm_sel;
            e.wr = vt[i].wr;
            e.sel = vt[i].sel;
            e.dreq = vt[i].dreq;
            e.we = vt[i].we;
            e.mdr = vt[i].mdr;
            e.pc = vt[i].pc;
            if (vt[i].wr != 0) begin
                e.rd = vt[i].ins[11:8];
                e.rs = vt[i].ins[7:4];
                e.rt = vt[i].ins[3:0];
            end
            cmp($sformatf("vec%0d", i), r, e);
            mpc = vt[i].pc;
            $display("vec %0d ins=%h z=%0d: cycles=%0d pc=%h", i, vt[i].ins, vt[i].z, r.cycles, r.pc);
        end

        // Randomized instructions with stray acks, checked against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 14));
            rins = {rop, 12'($urandom)};
            iw = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            z = 1'($urandom_range(0, 1));
            run_instr(rins, iw, dw, z, 1'b1, r);
            e = model(rins, dw, z, mpc);
            cmp($sformatf("rnd%0d", i), r, e);
            mpc = e.pc;
            $display("rnd %0d ins=%h iw=%0d dw=%0d z=%0d: cycles=%0d pc=%h", i, rins, iw, dw, z, r.cycles, r.pc);
        end

        // Fetch timeout: 15 unacked request cycles end in FAULT.
        bus.imem_ack = 1'b0;
        for (int k = 0; k < 14; k++) step();
        chk("timeout.pre_fault", {31'd0, fault}, 32'd0);
        chk("timeout.req_held", {31'd0, bus.imem_req}, 32'd1);
        step();
        chk("timeout.fault", {31'd0, fault}, 32'd1);
        chk("timeout.req_drop", {31'd0, bus.imem_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            start = ~start;
            step();
        end
        start = 1'b0;
        chk("fault.sticky", {31'd0, fault}, 32'd1);
        chk("fault.no_fetch", {31'd0, bus.imem_req}, 32'd0);
        $display("fetch timeout: fault=%0d", fault);

        // Ack on the limit cycle wins over the timeout.
        do_reset();
        chk("reset_clears_fault", {31'd0, fault}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(16'h0000, 14, 0, 1'b0, 1'b0, r);
        e = model(16'h0000, 0, 1'b0, 16'h0000);
        cmp("ack_on_limit", r, e);
        chk("ack_on_limit.no_fault", {31'd0, fault}, 32'd0);
        $display("ack on cycle 15: fault=%0d pc=%h", fault, r.pc);

        // Asynchronous reset in the middle of a data-memory handshake.
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h8450;
        step();
        bus.imem_ack = 1'b0;
        step();
        step();
        chk("mem.dmem_req", {31'd0, bus.dmem_req}, 32'd1);
        step();
        chk("mem.dmem_req_wait", {31'd0, bus.dmem_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst.dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("async_rst.pc", {16'd0, pc}, 32'h0);
        chk("async_rst.imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_rst.rd_addr", {28'd0, rf_rd_addr}, 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("async_rst.idle", {31'd0, bus.imem_req}, 32'd0);
        $display("reset during MEM: dmem_req=%0d pc=%h", bus.dmem_req, pc);

        // HALT is terminal; start toggling has no effect.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("halt.fetch", {31'd0, bus.imem_req}, 32'd1);
        run_instr(16'hF000, 0, 0, 1'b0, 1'b0, r);
        e = model(16'hF000, 0, 1'b0, 16'h0000);
        cmp("halt", r, e);
        for (int k = 0; k < 6; k++) begin
            start = ~start;
            step();
        end
        start = 1'b0;
        chk("halt.sticky", {31'd0, halted}, 32'd1);
        chk("halt.no_fetch", {31'd0, bus.imem_req}, 32'd0);
        chk("halt.no_wr", {31'd0, rf_write_en}, 32'd0);
        $display("halt: halted=%0d pc=%h", halted, pc);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded at reset.
REQ-002 Parameter WAIT_LIMIT, default 15, SHALL be the maximum wait cycles for a memory ack; 0 disables the timeout.
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL be the level run request, sampled only in IDLE.
REQ-006 imem_req / imem_ack / imem_rdata  out 1 / in 1 / in 16  SHALL be the instruction-fetch handshake and data; address = pc.
REQ-007 dmem_req / dmem_we / dmem_ack  out 1 / out 1 / in 1  SHALL be the data-memory handshake; the datapath ALU result is the address.
REQ-008 mdr_load  out  1  SHALL strobe the datapath memory-data register.
REQ-009 pc  out  16  SHALL be the program counter.
REQ-010 rf_rs_addr / rf_rt_addr / rf_rd_addr  out  4 each  SHALL equal ir[7:4] / ir[3:0] / ir[11:8] at all times.
REQ-011 rf_write_en / rf_wdata_sel  out  1 / 1  SHALL be the RF write strobe and write-data select (0 = ALU, 1 = MDR).
REQ-012 alu_op / alu_src_imm / imm  out  3 / 1 / 16  SHALL be the ALU operation, the B-operand select (1 = imm), and sign-extended ir[3:0].
REQ-013 halted / fault  out  1 / 1  SHALL be the status flags.

Function
REQ-014 Instruction fields: opcode = ir[15:12]; 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 7 ADDI, 8 LW rd<-[rs], 9 SW [rs]<-rt, A BEQ rs,rt,ir[11:8], B JMP ir[11:0], F HALT; all other opcodes SHALL execute as NOP.
REQ-015 State encoding SHALL be: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT; outputs SHALL be combinational from state and ir only.
REQ-016 IDLE: all strobes 0; start=1 -> FETCH on the next cycle.
REQ-017 FETCH: imem_req=1; ack=1 in the same cycle -> ir<=imem_rdata, pc<=pc+1 (16'hFFFF wraps to 0), next DECODE.
REQ-018 DECODE: one cycle; HALT -> HALT; JMP -> pc<={4'h0, ir[11:0]}, next FETCH; all others -> EXEC.
REQ-019 EXEC alu_op: ADD/ADDI 000, SUB/BEQ 001, AND 010, OR 011, XOR 100, LW/SW 101 (pass A); alu_src_imm=1 only for ADDI.
REQ-020 EXEC next state: ALU ops/ADDI -> WB; LW/SW -> MEM; BEQ -> FETCH, with pc<=pc+imm4 sign-extended from ir[11:8] if alu_zero=1 (mod 2^16); NOP -> FETCH.
REQ-021 MEM: dmem_req=1, dmem_we=1 only for SW; on dmem_ack: LW -> mdr_load=1 that cycle, next WB; SW -> next FETCH.
REQ-022 WB: rf_write_en=1 for exactly one cycle, rf_wdata_sel=1 for LW else 0; next FETCH; rd=0 still pulses rf_write_en (the RF discards r0 writes).
REQ-023 Wait counter SHALL clear on entry to FETCH/MEM and count each cycle with req=1 and ack=0; if WAIT_LIMIT consecutive unacked cycles elapse -> FAULT; an ack on the limit cycle wins.
REQ-024 Latency with zero-wait ack SHALL be: ALU/ADDI 4 cycles, LW 5, SW 4, BEQ 3, JMP 2, NOP 3.
REQ-025 HALT: halted=1; FAULT: fault=1; both SHALL be terminal until reset, with start ignored and all strobes 0.
REQ-026 req SHALL stay asserted until ack; ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, pc=RESET_PC, ir=16'h0000, wait counter=0, all strobes/flags 0, including mid-handshake; operation resumes only via start.

Verification
REQ-028 Reset, start=1, imem returns 16'h1321 with zero-wait ack -> rf_write_en pulses in cycle 4, rf_rd_addr=3, rs=2, rt=1, alu_op=000, pc=1.
REQ-029 LW 16'h8450 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, mdr_load in the ack cycle, WB with rf_wdata_sel=1.
REQ-030 BEQ 16'hA312 at pc=16'h0010: alu_zero=1 -> next fetch at pc=16'h0011+3=16'h0014; imm field 4'hE -> 16'h000F; alu_zero=0 -> 16'h0011.
REQ-031 imem_ack held 0 with WAIT_LIMIT=15 -> FAULT after 15 req cycles, fault=1; ack on cycle 15 -> DECODE instead.
REQ-032 JMP 16'hB123 -> pc=16'h0123; HALT 16'hF000 -> halted=1, start toggling has no effect.
REQ-033 pc=16'hFFFF fetch -> pc wraps to 16'h0000; rst=0 asserted during MEM -> IDLE, dmem_req=0 asynchronously.
